adat_frame_streamer: RTL and testbench
======================================

// Module: adat_frame_streamer
// PURPOSE
//  Downstream of the ADAT receiver: takes each decoded 8-channel frame (o_channels/o_user on the
//  o_valid pulse) and queues it in a small frame FIFO. Replays each frame as a valid/ready stream,
//  one 24-bit sample per beat, with channel index and end-of-frame marker.
//  Decouples the receiver's fixed frame timing from back-pressured consumers (DSP, DMA, TDM tx).
// PARAMETERS
//  DEPTH    2   frames of buffering; power of two, >= 2
//  DATA_W   24  sample width, bits
//  NUM_CH   8   channels per frame; fixed at 8 (o_tchan is 3 bits)
// PORTS
//  i_clk            in   1               system clock (same domain as adat_rx)
//  i_rst            in   1               async reset, active-low
//  i_channels       in   [0:7][DATA_W]   frame samples from receiver
//  i_user           in   4               user bits of the frame
//  i_valid          in   1               1-cycle pulse: frame on i_channels/i_user is complete
//  i_locked         in   1               receiver lock status
//  o_tdata          out  DATA_W          sample of current beat
//  o_tchan          out  3               channel index of current beat, 0..7
//  o_tuser          out  4               user bits of the frame being sent (constant across frame)
//  o_tlast          out  1               high on channel-7 beat
//  o_tvalid         out  1               beat available
//  i_tready         in   1               consumer accepts beat
//  o_level          out  $clog2(DEPTH)+1 frames stored, including the one being sent
//  o_overflow       out  1               sticky: a frame was dropped
//  i_clr_overflow   in   1               clears o_overflow
// BEHAVIOUR
//  - Reset (i_rst=0, async): all outputs 0; FIFO empty; channel counter 0; state IDLE.
//  - Write: i_valid && i_locked && (level<DEPTH || pop this cycle) -> store all 8 samples + user
//    as one entry at the write pointer. i_valid while !i_locked is ignored (no write, no overflow).
//  - Overflow: i_valid && i_locked && level==DEPTH && no pop this cycle -> frame dropped,
//    o_overflow=1 next cycle. Set wins over i_clr_overflow in the same cycle.
//  - Read FSM: IDLE -> SEND when level>0 (o_tvalid=1 cycle after entry). In SEND: beat = entry[ch].
//    Transfer = o_tvalid && i_tready -> ch+1. At ch==7 transfer: o_tlast was 1; pop entry; ch=0;
//    stay SEND if another entry remains (no bubble), else IDLE.
//  - Outputs are registered. While o_tvalid && !i_tready, o_tdata/o_tchan/o_tuser/o_tlast hold.
//    o_tvalid never drops mid-frame.
//  - Latency: i_valid at edge N with FIFO empty -> o_tvalid, ch0 data visible after edge N+1.
//    Full frame drains in 8 cycles with i_tready=1.
//  - Simultaneous write + pop: level unchanged; the new frame is accepted even when level==DEPTH.
//  - Lock loss (i_locked 1->0): the frame in progress completes normally through tlast. All queued
//    frames not yet started are discarded at the next edge. Level then becomes 1 or 0. No overflow.
//  - Pointers wrap modulo DEPTH; level = 0..DEPTH, saturation is impossible by construction.
//  - Frame rate at 48k is ~2083 clk/frame @100MHz; a full frame fits with tready duty >= 8/2083.
//  - Sample rate and SMUX are not interpreted; samples pass through in received channel order.
// TESTING
//  1 reset: hold i_rst=0, toggle inputs -> all outputs 0; after release o_tvalid=0, o_level=0.
//  2 single frame, i_tready=1: channels 0x123456..0xABCDEF, user 0xA -> 8 beats in order;
//    o_tchan 0..7; o_tuser=0xA; o_tlast only on 0xABCDEF; o_level 1->0.
//  3 back-pressure: i_tready toggling 1010.., then held 0 for 20 cycles mid-frame ->
//    data/tchan stable while stalled; no beat lost or duplicated.
//  4 overflow: i_tready=0, DEPTH+1 frames pushed -> o_level=DEPTH; o_overflow=1 after last push.
//    Drain yields the first DEPTH frames intact. i_clr_overflow -> o_overflow=0.
//  5 write+pop same cycle with FIFO full: i_valid aligned to ch7 transfer -> frame accepted,
//    o_overflow stays 0.
//  6 lock loss: 2 frames queued, drop i_locked during ch3 of first -> first frame finishes with tlast;
//    second discarded; o_level=0; an i_valid while unlocked is ignored.
//  All scenarios: a scoreboard compares every beat against the expected frame queue.

Source files
------------

// File: rtl/adat_frame_streamer.sv
// adat_frame_streamer: queues decoded ADAT frames and replays them as a valid/ready sample stream
// Ports: i_clk/i_rst (async, active-low); i_channels/i_user/i_valid/i_locked frame input from the
// receiver; o_tdata/o_tchan/o_tuser/o_tlast/o_tvalid/i_tready sample stream; o_level frames held;
// o_overflow sticky drop flag, cleared by i_clr_overflow.
module adat_frame_streamer #(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 24,
    parameter int NUM_CH = 8
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [0:NUM_CH-1][DATA_W-1:0] i_channels,
    input  logic [3:0]                    i_user,
    input  logic                          i_valid,
    input  logic                          i_locked,
    output logic [DATA_W-1:0]             o_tdata,
    output logic [2:0]                    o_tchan,
    output logic [3:0]                    o_tuser,
    output logic                          o_tlast,
    output logic                          o_tvalid,
    input  logic                          i_tready,
    output logic [$clog2(DEPTH):0]        o_level,
    output logic                          o_overflow,
    input  logic                          i_clr_overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL = LW'(DEPTH);
    typedef enum logic {IDLE, SEND} state_t;
    state_t state;
    logic [AW-1:0] wr_ptr, rd_ptr, rd_next, nxt_ptr;
    logic [LW-1:0] level_next;
    logic xfer, pop, wr, ovf_set, keep;
    logic [0:NUM_CH-1][DATA_W-1:0] data_mem [DEPTH];
    logic [3:0] user_mem [DEPTH];
    // A pop frees a slot in the same cycle, so a full FIFO still accepts a frame on the last beat.
    // While unlocked only the frame already on the stream (keep) survives; everything else is dropped.
    always_comb begin
        xfer       = o_tvalid && i_tready;
        pop        = xfer && o_tchan == 3'd7;
        wr         = i_valid && i_locked && (o_level != FULL || pop);
        ovf_set    = i_valid && i_locked && o_level == FULL && !pop;
        keep       = state == SEND && !pop;
        rd_next    = rd_ptr + AW'(pop);
        nxt_ptr    = rd_ptr + AW'(1);
        level_next = i_locked ? o_level + LW'(wr) - LW'(pop) : LW'(keep);
    end
    always_ff @(posedge i_clk) begin
        if (wr) begin
            data_mem[wr_ptr] <= i_channels;
            user_mem[wr_ptr] <= i_user;
        end
    end
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            o_level    <= '0;
            o_overflow <= 1'b0;
            o_tdata    <= '0;
            o_tchan    <= '0;
            o_tuser    <= '0;
            o_tlast    <= 1'b0;
            o_tvalid   <= 1'b0;
        end else begin
            rd_ptr     <= rd_next;
            wr_ptr     <= i_locked ? wr_ptr + AW'(wr) : rd_next + AW'(keep);
            o_level    <= level_next;
            o_overflow <= ovf_set || (o_overflow && !i_clr_overflow);
            if (state == IDLE) begin
                if (o_level != '0 && i_locked) begin
                    state    <= SEND;
                    o_tvalid <= 1'b1;
                    o_tchan  <= '0;
                    o_tlast  <= 1'b0;
                    o_tdata  <= data_mem[rd_ptr][0];
                    o_tuser  <= user_mem[rd_ptr];
                end
            end else if (pop) begin
                o_tchan <= '0;
                o_tlast <= 1'b0;
                if (level_next == '0) begin
                    state    <= IDLE;
                    o_tvalid <= 1'b0;
                end else begin
                    // With one entry left the next frame is the one being written now: bypass memory.
                    o_tdata <= o_level == LW'(1) ? i_channels[0] : data_mem[nxt_ptr][0];
                    o_tuser <= o_level == LW'(1) ? i_user : user_mem[nxt_ptr];
                end
            end else if (xfer) begin
                o_tchan <= o_tchan + 3'd1;
                o_tlast <= o_tchan == 3'd6;
                o_tdata <= data_mem[rd_ptr][o_tchan + 3'd1];
            end
        end
    end
endmodule

// File: tb/tb_adat_frame_streamer.sv
// tb_adat_frame_streamer: directed vectors plus beat scoreboard for adat_frame_streamer
module tb_adat_frame_streamer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [0:7][23:0] i_channels = '0;
    logic [3:0] i_user = '0;
    logic i_valid = 1'b0, i_locked = 1'b1, i_tready = 1'b0, i_clr_overflow = 1'b0;
    logic [23:0] o_tdata;
    logic [2:0] o_tchan;
    logic [3:0] o_tuser;
    logic o_tlast, o_tvalid, o_overflow;
    logic [1:0] o_level;
    int tests = 0, fails = 0;
    typedef struct { logic [23:0] d; logic [2:0] c; logic [3:0] u; logic l; } beat_t;
    typedef struct { logic v; logic r; logic ev; logic [2:0] ec; logic [23:0] ed; logic el; logic [1:0] elev; } vec_t;
    beat_t exp_q[$];
    beat_t b;
    vec_t tbl [10];
    logic [0:7][23:0] fr [14];
    logic [3:0] fu [14];
    logic stall_prev = 1'b0;
    logic [32:0] hold_prev;
    adat_frame_streamer #(.DEPTH(2), .DATA_W(24), .NUM_CH(8)) dut (
        .i_clk(clk), .i_rst(rst_n), .i_channels(i_channels), .i_user(i_user),
        .i_valid(i_valid), .i_locked(i_locked), .o_tdata(o_tdata), .o_tchan(o_tchan),
        .o_tuser(o_tuser), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .i_tready(i_tready),
        .o_level(o_level), .o_overflow(o_overflow), .i_clr_overflow(i_clr_overflow)
    );
    always #5 clk = ~clk;
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic push(input int k);
        i_channels = fr[k];
        i_user = fu[k];
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
    endtask
    task automatic expect_frame(input int k);
        for (int c = 0; c < 8; c++) exp_q.push_back('{fr[k][c], 3'(c), fu[k], c == 7});
    endtask
    task automatic drain(input string name);
        int n = 0;
        i_tready = 1'b1;
        while ((o_tvalid || o_level != 0) && n < 100) begin
            tick();
            n++;
        end
        check({name, " drained"}, 64'(o_tvalid || o_level != 0), 0);
        check({name, " all beats seen"}, 64'(exp_q.size()), 0);
    endtask
    // Scoreboard: every accepted beat must match the head of the expected queue; stalled beats must hold.
    always @(negedge clk) begin
        if (!rst_n) stall_prev = 1'b0;
        else begin
            if (stall_prev) check("stall hold", 64'({o_tvalid, o_tdata, o_tchan, o_tuser, o_tlast}), 64'(hold_prev));
            if (o_tvalid && i_tready) begin
                if (exp_q.size() == 0) check("unexpected beat", 64'({o_tdata, o_tchan}), 0);
                else begin
                    b = exp_q.pop_front();
                    check("beat", 64'({o_tdata, o_tchan, o_tuser, o_tlast}), 64'({b.d, b.c, b.u, b.l}));
                end
            end
            stall_prev = o_tvalid && !i_tready;
            hold_prev = {o_tvalid, o_tdata, o_tchan, o_tuser, o_tlast};
        end
    end
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
    initial begin
        int n;
        logic [23:0] spec_fr [8] = '{24'h123456, 24'h234567, 24'h345678, 24'h456789,
                                     24'h56789A, 24'h6789AB, 24'h789ABC, 24'hABCDEF};
        for (int c = 0; c < 8; c++) fr[0][c] = spec_fr[c];
        fu[0] = 4'hA;
        for (int k = 1; k < 14; k++) begin
            for (int c = 0; c < 8; c++) fr[k][c] = {4'(k), 4'(c), 16'hBEEF ^ 16'(k * 37 + c)};
            fu[k] = 4'(k);
        end
        tbl[0] = '{1'b1, 1'b1, 1'b0, 3'd0, 24'h0, 1'b0, 2'd1};
        for (int k = 1; k <= 8; k++) tbl[k] = '{1'b0, 1'b1, 1'b1, 3'(k - 1), spec_fr[k - 1], k == 8, 2'd1};
        tbl[9] = '{1'b0, 1'b1, 1'b0, 3'd0, 24'h0, 1'b0, 2'd0};
        // 1: reset holds every output low regardless of inputs
        i_channels = fr[0];
        for (int i = 0; i < 4; i++) begin
            i_valid = i[0];
            i_tready = ~i[0];
            i_clr_overflow = i[1];
            tick();
            check("reset outputs", 64'({o_tdata, o_tchan, o_tuser, o_tlast, o_tvalid, o_level, o_overflow}), 0);
        end
        i_valid = 1'b0;
        i_clr_overflow = 1'b0;
        rst_n = 1'b1;
        tick();
        check("post reset tvalid", 64'(o_tvalid), 0);
        check("post reset level", 64'(o_level), 0);
        // 2: single frame, table driven
        expect_frame(0);
        i_channels = fr[0];
        i_user = fu[0];
        for (int i = 0; i < 10; i++) begin
            i_valid = tbl[i].v;
            i_tready = tbl[i].r;
            tick();
            check($sformatf("t2 row%0d tvalid", i), 64'(o_tvalid), 64'(tbl[i].ev));
            check($sformatf("t2 row%0d level", i), 64'(o_level), 64'(tbl[i].elev));
            if (tbl[i].ev)
                check($sformatf("t2 row%0d beat", i), 64'({o_tdata, o_tchan, o_tlast, o_tuser}),
                      64'({tbl[i].ed, tbl[i].ec, tbl[i].el, 4'hA}));
        end
        check("t2 all beats seen", 64'(exp_q.size()), 0);
        // 3: back-pressure, toggling then a long stall mid-frame
        i_tready = 1'b0;
        push(2);
        expect_frame(2);
        for (int i = 0; i < 8; i++) begin
            i_tready = (i % 2 == 0);
            tick();
        end
        i_tready = 1'b0;
        repeat (20) tick();
        check("t3 stalled mid-frame", 64'({o_tvalid, o_tchan}), 64'({1'b1, 3'd3}));
        check("t3 stalled data", 64'(o_tdata), 64'(fr[2][3]));
        drain("t3");
        // 4: overflow with consumer stalled
        i_tready = 1'b0;
        push(3);
        expect_frame(3);
        push(4);
        expect_frame(4);
        check("t4 no overflow yet", 64'(o_overflow), 0);
        push(5);
        check("t4 level full", 64'(o_level), 2);
        check("t4 overflow set", 64'(o_overflow), 1);
        i_clr_overflow = 1'b1;
        push(6);
        i_clr_overflow = 1'b0;
        check("t4 set beats clear", 64'(o_overflow), 1);
        drain("t4");
        check("t4 overflow sticky", 64'(o_overflow), 1);
        i_clr_overflow = 1'b1;
        tick();
        i_clr_overflow = 1'b0;
        check("t4 overflow cleared", 64'(o_overflow), 0);
        // 5: write on the last beat while full, then while one frame left (no bubble)
        i_tready = 1'b0;
        push(7);
        expect_frame(7);
        push(8);
        expect_frame(8);
        i_tready = 1'b1;
        n = 0;
        while (!(o_tvalid && o_tchan == 3'd7) && n < 20) begin
            tick();
            n++;
        end
        check("t5 reached ch7 full", 64'(o_tvalid && o_tchan == 3'd7 && o_level == 2), 1);
        push(9);
        expect_frame(9);
        check("t5 full write+pop overflow", 64'(o_overflow), 0);
        check("t5 full write+pop level", 64'(o_level), 2);
        n = 0;
        while (!(o_tvalid && o_tchan == 3'd7 && o_level == 1) && n < 40) begin
            tick();
            n++;
        end
        check("t5 reached ch7 single", 64'(o_tvalid && o_tchan == 3'd7 && o_level == 1), 1);
        push(10);
        expect_frame(10);
        check("t5 bypass next beat", 64'({o_tvalid, o_tchan, o_tdata, o_tuser, o_level}),
              64'({1'b1, 3'd0, fr[10][0], fu[10], 2'd1}));
        drain("t5");
        check("t5 overflow clear", 64'(o_overflow), 0);
        // 6: lock loss mid-frame
        i_tready = 1'b0;
        push(11);
        expect_frame(11);
        push(12);
        i_tready = 1'b1;
        n = 0;
        while (!(o_tvalid && o_tchan == 3'd3) && n < 20) begin
            tick();
            n++;
        end
        check("t6 reached ch3", 64'(o_tvalid && o_tchan == 3'd3), 1);
        i_locked = 1'b0;
        push(13);
        check("t6 queued discarded", 64'(o_level), 1);
        drain("t6");
        check("t6 no overflow", 64'(o_overflow), 0);
        push(13);
        tick();
        check("t6 unlocked frame ignored", 64'({o_level, o_tvalid}), 0);
        i_locked = 1'b1;
        push(13);
        expect_frame(13);
        drain("t6 relock");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
